// File: rtl/pattern_stim_seq_if.sv
// Table write port of the stimulus sequencer: one (level, duration) entry per valid/ready beat.
interface pattern_stim_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_level;
  logic [CNT_W-1:0] wr_dur;

  modport master (output wr_valid, output wr_level, output wr_dur, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_level, input  wr_dur, output wr_ready);
endinterface

// File: rtl/pattern_stim_seq.sv
// Programmable stimulus sequencer: plays a (level, duration) table a fixed number
// of passes or forever, driving a registered level into downstream analog models.
module pattern_stim_seq #(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 16,
  parameter int               CNT_W      = 16,
  parameter logic [WIDTH-1:0] IDLE_LEVEL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  pattern_stim_seq_if.slave          wr,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       stop,
  input  logic [7:0]                 repeat_n,
  output logic [WIDTH-1:0]           level_out,
  output logic                       level_valid,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [0:0]    S_IDLE = 1'b0;
  localparam logic [0:0]    S_RUN  = 1'b1;

  typedef struct packed {
    logic [WIDTH-1:0] level;
    logic [CNT_W-1:0] dur;
  } entry_t;

  entry_t          tbl [DEPTH];
  logic [0:0]      state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   idx, nidx;
  logic [7:0]      pass, rep;
  logic [CNT_W-1:0] rem;
  logic            last_entry, more_pass, wr_fire;

  // rem counts cycles left after the current one, so dur=0 and dur=1 both hold one cycle
  function automatic logic [CNT_W-1:0] hold(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  assign count       = cnt;
  assign busy        = (state == S_RUN);
  assign level_valid = (state == S_RUN);
  assign wr.wr_ready = rst_n && (state == S_IDLE) && !cnt[AW];
  assign wr_fire     = wr.wr_valid && wr.wr_ready && !clear;

  always_comb begin
    last_entry = ({1'b0, idx} == (cnt - ONE));
    more_pass  = (rep == 8'd0) || (pass < rep);
    nidx       = last_entry ? '0 : idx + AW'(1);
  end

  // Table has no reset; count=0 makes stale entries unreachable
  always_ff @(posedge clk) begin
    if (wr_fire) tbl[cnt[AW-1:0]] <= '{level: wr.wr_level, dur: wr.wr_dur};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      pass      <= '0;
      rep       <= '0;
      rem       <= '0;
      level_out <= IDLE_LEVEL;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clear)        cnt <= '0;
          else if (wr_fire) cnt <= cnt + ONE;
          // clear also blocks start so a just-emptied table is never played
          if (start && !stop && !clear && cnt != '0) begin
            state     <= S_RUN;
            rep       <= repeat_n;
            idx       <= '0;
            pass      <= 8'd1;
            rem       <= hold(tbl[0].dur);
            level_out <= tbl[0].level;
          end
        end
        default: begin
          if (stop) begin
            state     <= S_IDLE;
            level_out <= IDLE_LEVEL;
          end else if (rem != '0) begin
            rem <= rem - CNT_W'(1);
          end else if (!last_entry || more_pass) begin
            idx       <= nidx;
            rem       <= hold(tbl[nidx].dur);
            level_out <= tbl[nidx].level;
            if (last_entry && pass != 8'hff) pass <= pass + 8'd1;
          end else begin
            state     <= S_IDLE;
            level_out <= IDLE_LEVEL;
            done      <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_stim_seq.sv
// Directed bench for pattern_stim_seq: playback timing, repeats, abort, full table, reset.
module tb_pattern_stim_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0, start = 1'b0, stop = 1'b0;
  logic [7:0] repeat_n = 8'd0;
  logic [7:0] level_out;
  logic       level_valid, busy, done;
  logic [4:0] count;
  int         n_chk = 0, n_pass = 0;

  pattern_stim_seq_if #(.WIDTH(8), .CNT_W(16)) wif ();

  pattern_stim_seq #(.WIDTH(8), .DEPTH(16), .CNT_W(16), .IDLE_LEVEL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wif), .clear(clear), .start(start), .stop(stop),
    .repeat_n(repeat_n), .level_out(level_out), .level_valid(level_valid),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] lvl, input logic [15:0] dur);
    wif.wr_valid = 1'b1; wif.wr_level = lvl; wif.wr_dur = dur;
    tick();
    wif.wr_valid = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] rn);
    repeat_n = rn; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load3();
    load(8'h10, 16'd2);
    load(8'h20, 16'd0);
    load(8'h30, 16'd3);
  endtask

  // Expected level in cycle c (1-based) of a looping (0x10,2),(0x20,0),(0x30,3) table
  function automatic logic [7:0] pat(input int c);
    int p;
    p = (c - 1) % 6;
    if (p < 2) return 8'h10;
    if (p == 2) return 8'h20;
    return 8'h30;
  endfunction

  initial begin
    wif.wr_valid = 1'b0; wif.wr_level = '0; wif.wr_dur = '0;
    #2;
    chk("rst wr_ready", wif.wr_ready, 1'b0);
    chk("rst level", level_out, 8'h00);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst count", count, 5'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle wr_ready", wif.wr_ready, 1'b1);

    // Basic playback, repeat_n=1
    load3();
    chk("t1 count", count, 5'd3);
    do_start(8'd1);
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("t1 lvl c%0d", c), level_out, (c <= 6) ? pat(c) : 8'h00);
      chk($sformatf("t1 busy c%0d", c), busy, (c <= 6));
      chk($sformatf("t1 lv c%0d", c), level_valid, (c <= 6));
      chk($sformatf("t1 done c%0d", c), done, (c == 7));
      chk($sformatf("t1 rdy c%0d", c), wif.wr_ready, (c > 6));
      tick();
    end

    // Two passes back to back
    do_start(8'd2);
    for (int c = 1; c <= 14; c++) begin
      chk($sformatf("t2 lvl c%0d", c), level_out, (c <= 12) ? pat(c) : 8'h00);
      chk($sformatf("t2 busy c%0d", c), busy, (c <= 12));
      chk($sformatf("t2 done c%0d", c), done, (c == 13));
      if (c < 14) tick();
    end
    tick();

    // Infinite run, stop sampled at cycle 20
    do_start(8'd0);
    for (int c = 1; c <= 20; c++) begin
      chk($sformatf("t3 lvl c%0d", c), level_out, pat(c));
      chk($sformatf("t3 done c%0d", c), done, 1'b0);
      chk($sformatf("t3 count c%0d", c), count, 5'd3);
      if (c == 20) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    chk("t3 stop lvl", level_out, 8'h00);
    chk("t3 stop busy", busy, 1'b0);
    chk("t3 stop done", done, 1'b0);
    tick();
    chk("t3 after done", done, 1'b0);

    // start+stop together with count=3
    start = 1'b1; stop = 1'b1; repeat_n = 8'd1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("t5 ss busy", busy, 1'b0);
    chk("t5 ss lvl", level_out, 8'h00);
    tick();
    chk("t5 ss busy2", busy, 1'b0);

    // start with empty table
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5 clr count", count, 5'd0);
    do_start(8'd1);
    chk("t5 empty busy", busy, 1'b0);
    chk("t5 empty lvl", level_out, 8'h00);
    tick();
    chk("t5 empty done", done, 1'b0);

    // Full table: 17 offers, 16 accepted
    wif.wr_valid = 1'b1; wif.wr_dur = 16'd1;
    for (int i = 0; i < 17; i++) begin
      wif.wr_level = 8'(8'h41 + i);
      chk($sformatf("t4 rdy i%0d", i), wif.wr_ready, (i < 16));
      tick();
    end
    wif.wr_valid = 1'b0;
    chk("t4 count", count, 5'd16);
    chk("t4 rdy full", wif.wr_ready, 1'b0);
    do_start(8'd1);
    for (int c = 1; c <= 17; c++) begin
      chk($sformatf("t4 lvl c%0d", c), level_out, (c <= 16) ? 8'(8'h40 + c) : 8'h00);
      chk($sformatf("t4 done c%0d", c), done, (c == 17));
      tick();
    end
    chk("t4 count2", count, 5'd16);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t4 clr count", count, 5'd0);
    chk("t4 clr rdy", wif.wr_ready, 1'b1);

    // Clear and write in the same cycle: write is dropped
    wif.wr_valid = 1'b1; wif.wr_level = 8'h77; clear = 1'b1;
    tick();
    wif.wr_valid = 1'b0; clear = 1'b0;
    chk("t4 clr+wr count", count, 5'd0);

    // Reset asynchronously while showing 0x30
    load3();
    do_start(8'd0);
    tick(); tick(); tick();
    chk("t6 pre lvl", level_out, 8'h30);
    chk("t6 pre busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async lvl", level_out, 8'h00);
    chk("t6 async busy", busy, 1'b0);
    chk("t6 async lv", level_valid, 1'b0);
    chk("t6 async count", count, 5'd0);
    chk("t6 async rdy", wif.wr_ready, 1'b0);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("t6 post done c%0d", c), done, 1'b0);
      chk($sformatf("t6 post busy c%0d", c), busy, 1'b0);
      chk($sformatf("t6 post lvl c%0d", c), level_out, 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
